seg_scan_display: RTL

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/cpu24_disp_pkg.sv | 13 +
 rtl/hex7seg_decoder.sv | 11 +
 rtl/seg_scan_display.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu24_disp_pkg.sv
// Shared constants for the scanned seven-segment display: default scan rate,
// digit count and the active-low hex segment table (bit order g..a).
package cpu24_disp_pkg;

    localparam int CLK_DIV_DEFAULT = 100000;
    localparam int NDIG            = 8;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module hex7seg_decoder
    import cpu24_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 8-digit hex display with frame-synchronous updates.
// Define LEADING_ZERO_BLANK_EN to blank digits above the highest nonzero nibble.
module seg_scan_display #(
    parameter int CLK_DIV = cpu24_disp_pkg::CLK_DIV_DEFAULT,
    parameter int NDIG    = cpu24_disp_pkg::NDIG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] data_in,
    input  logic              load,
    output logic [NDIG-1:0]   an,
    output logic [7:0]        seg,
    output logic              pending,
    output logic              frame_done
);

    localparam int              PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int              IW       = $clog2(NDIG);
    localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);

    logic [PW-1:0]     pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic [4*NDIG-1:0] disp_q, disp_d;
    logic              pending_q, pending_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic              tick;
    logic              boundary;
    logic              blank;
    logic [3:0]        nibble;
    logic [6:0]        seg_raw;

    assign tick     = (pre_q == PRE_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);
    assign nibble   = disp_q[{idx_q, 2'b00} +: 4];

    hex7seg_decoder u_dec (
        .nibble_i (nibble),
        .seg_n_o  (seg_raw)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [IW-1:0] top_digit;

    always_comb begin
        top_digit = '0;
        for (int i = 1; i < NDIG; i++) begin
            if (disp_q[4*i +: 4] != 4'h0) top_digit = IW'(i);
        end
    end

    // Digit 0 can never exceed top_digit, so it always stays lit.
    assign blank = (idx_q > top_digit);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets a default before any branch so no latch is inferred.
        pre_d     = tick ? '0 : pre_q + 1'b1;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;

        if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        // The display register only moves on a frame boundary, so a frame never tears.
        if (boundary && load) begin
            disp_d    = data_in;
            shadow_d  = data_in;
            pending_d = 1'b0;
        end else if (boundary && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = data_in;
            pending_d = 1'b1;
        end

        an_d  = blank ? '1 : ~(NDIG'(1) << idx_q);
        seg_d = {1'b1, seg_raw};
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is tested inside the clocked block, making it synchronous.
        if (rst) begin
            pre_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            seg_q     <= '1;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign pending    = pending_q;
    assign frame_done = boundary && !rst;

endmodule
